home_inventory_sample_framer: RTL
=================================

# home_inventory_sample_framer

Collects per-channel ADC words from the capture pipeline into complete 8-channel frames. Stamps each frame with a free-running timestamp and presents it to the event detector as a one-cycle `sample_valid` pulse with `ts_now` and `sample_ch0..7`. Sits directly upstream of the event detector and replaces the stub snapshot source used during bring-up.

## Interface
- `DATA_W`, 24: ADC word width, 1..32.
- `TS_DIV`, 1: clk cycles per timestamp tick, ≥1.
- `TIMEOUT`, 1024: max cycles from frame start to completion, ≥2.

- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: ADC word valid.
- `in_ready` out 1: word accepted when `in_valid & in_ready`.
- `in_ch` in 3: channel index of the word.
- `in_data` in DATA_W: ADC word, unsigned/offset-binary.
- `ch_mask` in 8: channels that make up a frame.
- `sample_valid` out 1: one-cycle frame-complete pulse.
- `ts_now` out 32: timestamp of the frame's first word.
- `sample_ch0..7` out 32 each: frame data, zero-extended.
- `frame_count` out 32: completed frames, saturating.
- `drop_count` out 16: timed-out partial frames, saturating.
- `dup_count` out 16: duplicate channel words inside a frame, saturating.

## Operation
- **Timestamp counter**
  - `ts_cnt` is 32 bits with a prescaler.
  - It increments once every `TS_DIV` clk cycles.
  - It wraps from 0xFFFF_FFFF to 0; downstream delta arithmetic is modulo 2^32.
- **Handshake**: `in_ready` = 1 whenever not in reset. Every offered word is consumed.
- **FSM IDLE**
  - A word whose `ch_mask[in_ch]` = 0 is discarded.
  - A word with its mask bit set starts a frame:
    - latch `fmask`=`ch_mask`, `fts`=`ts_cnt`;
    - store the word; set `got`=bit; clear `timer`;
    - go to COLLECT.
  - If `got == fmask` immediately (single-channel mask), the frame completes that cycle and the FSM stays in IDLE.
- **FSM COLLECT**
  - `timer` increments each cycle.
  - Words with `fmask[in_ch]` = 0 are discarded. Later `ch_mask` changes are ignored until the next frame.
  - A word for a channel already in `got` increments `dup_count` and overwrites the stored value.
  - When `got | bit == fmask`, the frame completes and the FSM returns to IDLE.
  - When `timer == TIMEOUT-1` without completion:
    - the partial frame is dropped;
    - `drop_count`++;
    - the FSM returns to IDLE;
    - stored data is not presented.
  - A completing word on the timeout cycle wins: the frame completes and nothing is dropped.
- **Completion**
  - The staging buffer is copied to the `sample_chN` output registers.
  - Channels not in `fmask` are driven 0.
  - `ts_now` ← `fts`; `frame_count`++.
- **`ch_mask` = 0**: all words are discarded and no frames are produced.
- **Reset values**: all outputs 0 except `in_ready`=0 during `rst`. FSM=IDLE, `ts_cnt`=0, prescaler=0, `got`=0.

## Timing
- `sample_valid` rises in the cycle after the completing word is accepted and lasts exactly one cycle.
- `sample_ch*` and `ts_now` update in the same cycle as `sample_valid` and hold until the next completion.
- A new frame's first word may be accepted in the same cycle `sample_valid` is high. Staging and output registers are separate, so back-to-back frames are lossless.
- Minimum frame period is `popcount(fmask)` cycles.
- Counter increments (`dup_count`, `drop_count`) are visible one cycle after the causing event.
- `rst` mid-frame discards the frame; no `sample_valid` is produced for it.

## Structure
- Shared package `home_inventory_pkg` holds:
  - `NUM_CH`=8, `TS_W`=32, `SAMPLE_W`=32;
  - the FSM state encoding (IDLE, COLLECT);
  - the saturating-increment helper (reused by the event detector).
- One sub-module: `home_inventory_ts_counter`, the prescaled 32-bit timestamp counter. Its `TS_DIV` parameter and tick-enable output are also usable by other blocks.

## Test plan
- **Full frame**: `ch_mask`=0xFF, `TS_DIV`=1; feed ch0..7 with data 0x10..0x17 on consecutive cycles starting at `ts_cnt`=5 → one `sample_valid` on cycle 9, `ts_now`=5, `sample_ch3`=0x13, `frame_count`=1.
- **Partial mask**: `ch_mask`=0x05; send ch1=0xAA, ch0=0x01, ch2=0x02 → `sample_valid` after ch2, `sample_ch1`=0, `sample_ch0`=1, `sample_ch2`=2.
- **Duplicate**: `ch_mask`=0x03; send ch0=1, ch0=7, ch1=3 → `dup_count`=1, `sample_ch0`=7, one frame.
- **Timeout**: `TIMEOUT`=16, `ch_mask`=0x03; send only ch0 → no `sample_valid`, `drop_count`=1 after 16 cycles. A subsequent full frame completes normally with a fresh `ts_now`.
- **Wrap and prescale**: `TS_DIV`=4, force `ts_cnt` near 0xFFFF_FFFE → ticks every 4 cycles, wraps to 0, and frames carry the wrapped value.
- **Reset mid-frame**: assert `rst` after 3 of 8 words → all outputs 0. A following full frame yields `frame_count`=1 and correct data.

Source files
------------

// File: rtl/home_inventory_pkg.sv
// Shared constants, FSM encoding and helpers for the home-inventory sampling chain
// (framer and event detector).
package home_inventory_pkg;

  localparam int unsigned NUM_CH   = 8;
  localparam int unsigned TS_W     = 32;
  localparam int unsigned SAMPLE_W = 32;

  typedef enum logic {
    IDLE,
    COLLECT
  } state_t;

  // Saturating increment; narrower counters pass a zero-extended value and their own max.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max);
    return (value >= max) ? max : value + 32'd1;
  endfunction

endpackage

// File: rtl/home_inventory_ts_counter.sv
// Free-running 32-bit timestamp advancing once every TS_DIV clocks; wraps modulo 2^32.
module home_inventory_ts_counter
  import home_inventory_pkg::*;
#(
  parameter int unsigned     TS_DIV  = 1,
  parameter logic [TS_W-1:0] TS_INIT = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            tick,
  output logic [TS_W-1:0] ts
);

  logic [31:0] presc;

  assign tick = (presc == TS_DIV - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      ts    <= TS_INIT;
    end else if (tick) begin
      presc <= '0;
      ts    <= ts + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

endmodule

// File: rtl/home_inventory_sample_framer.sv
// Gathers per-channel ADC words into timestamped 8-channel frames for the event detector,
// dropping partial frames that exceed TIMEOUT cycles.
module home_inventory_sample_framer
  import home_inventory_pkg::*;
#(
  parameter int unsigned     DATA_W  = 24,
  parameter int unsigned     TS_DIV  = 1,
  parameter int unsigned     TIMEOUT = 1024,
  parameter logic [TS_W-1:0] TS_INIT = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          in_ch,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [NUM_CH-1:0]   ch_mask,
  output logic                sample_valid,
  output logic [TS_W-1:0]     ts_now,
  output logic [SAMPLE_W-1:0] sample_ch0,
  output logic [SAMPLE_W-1:0] sample_ch1,
  output logic [SAMPLE_W-1:0] sample_ch2,
  output logic [SAMPLE_W-1:0] sample_ch3,
  output logic [SAMPLE_W-1:0] sample_ch4,
  output logic [SAMPLE_W-1:0] sample_ch5,
  output logic [SAMPLE_W-1:0] sample_ch6,
  output logic [SAMPLE_W-1:0] sample_ch7,
  output logic [31:0]         frame_count,
  output logic [15:0]         drop_count,
  output logic [15:0]         dup_count
);

  state_t              state, next_state;
  logic [TS_W-1:0]     ts;
  logic                accept, take, complete, start, drop, dup, timer_end;
  logic [NUM_CH-1:0]   ch_bit, cur_mask, merged, fmask, got;
  logic [31:0]         timer, dup_next, drop_next;
  logic [TS_W-1:0]     fts;
  logic [DATA_W-1:0]   stage    [NUM_CH];
  logic [SAMPLE_W-1:0] out_data [NUM_CH];

  home_inventory_ts_counter #(
    .TS_DIV  (TS_DIV),
    .TS_INIT (TS_INIT)
  ) u_ts (
    .clk  (clk),
    .rst  (rst),
    .tick (),
    .ts   (ts)
  );

  assign in_ready  = ~rst;
  assign accept    = in_valid & in_ready;
  assign ch_bit    = {{(NUM_CH-1){1'b0}}, 1'b1} << in_ch;
  // In IDLE the live mask decides; once collecting, the latched frame mask does.
  assign cur_mask  = (state == IDLE) ? ch_mask : fmask;
  assign take      = accept & cur_mask[in_ch];
  assign merged    = ((state == IDLE) ? '0 : got) | ch_bit;
  assign complete  = take && (merged == cur_mask);
  assign timer_end = (timer == TIMEOUT - 1);
  assign dup_next  = sat_inc({16'd0, dup_count}, 32'h0000_FFFF);
  assign drop_next = sat_inc({16'd0, drop_count}, 32'h0000_FFFF);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (take && !complete) next_state = COLLECT;
      COLLECT: if (complete || timer_end) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    start = 1'b0;
    drop  = 1'b0;
    dup   = 1'b0;
    case (state)
      IDLE:    start = take;
      COLLECT: begin
        dup  = take & got[in_ch];
        drop = !complete && timer_end;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (take) stage[in_ch] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fmask        <= '0;
      fts          <= '0;
      got          <= '0;
      timer        <= '0;
      sample_valid <= 1'b0;
      ts_now       <= '0;
      frame_count  <= '0;
      drop_count   <= '0;
      dup_count    <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) out_data[i] <= '0;
    end else begin
      sample_valid <= complete;
      if (start) begin
        fmask <= ch_mask;
        fts   <= ts;
        timer <= '0;
      end else if (state == COLLECT) begin
        timer <= timer + 1'b1;
      end
      if (complete || drop) got <= '0;
      else if (take)        got <= merged;
      // The completing word is bypassed into the outputs because staging updates on the same edge.
      if (complete) begin
        ts_now      <= (state == IDLE) ? ts : fts;
        frame_count <= sat_inc(frame_count, '1);
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          if (!cur_mask[i])       out_data[i] <= '0;
          else if (in_ch == 3'(i)) out_data[i] <= SAMPLE_W'(in_data);
          else                    out_data[i] <= SAMPLE_W'(stage[i]);
        end
      end
      if (drop) drop_count <= drop_next[15:0];
      if (dup)  dup_count  <= dup_next[15:0];
    end
  end

  assign sample_ch0 = out_data[0];
  assign sample_ch1 = out_data[1];
  assign sample_ch2 = out_data[2];
  assign sample_ch3 = out_data[3];
  assign sample_ch4 = out_data[4];
  assign sample_ch5 = out_data[5];
  assign sample_ch6 = out_data[6];
  assign sample_ch7 = out_data[7];

endmodule
